// File: rtl/width_16to8.sv
// width_16to8: unpacks each 16-bit word into two consecutive 8-bit bytes with valid/ready on both sides
module width_16to8 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] data_in,
  output logic        ready_in,
  output logic        valid_out,
  output logic [7:0]  data_out,
  output logic        last_out,
  input  logic        ready_out
);
  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;
  state_t state;
  logic [15:0] word;
  logic accept, xfer;
  logic [7:0] first_byte, second_byte;
  assign xfer = valid_out && ready_out;
  // SEND_LO always has valid_out=1, so ready_out here means the second byte leaves this cycle
  assign ready_in = !rst && (state == IDLE || (state == SEND_LO && ready_out));
  assign accept = valid_in && ready_in;
  assign first_byte = MSB_FIRST ? data_in[15:8] : data_in[7:0];
  assign second_byte = MSB_FIRST ? word[7:0] : word[15:8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid_out <= 1'b0;
      data_out <= 8'h00;
      last_out <= 1'b0;
      word <= 16'h0000;
    end else if (accept) begin
      word <= data_in;
      data_out <= first_byte;
      last_out <= 1'b0;
      valid_out <= 1'b1;
      state <= SEND_HI;
    end else if (state == SEND_HI && xfer) begin
      data_out <= second_byte;
      last_out <= 1'b1;
      state <= SEND_LO;
    end else if (state == SEND_LO && xfer) begin
      valid_out <= 1'b0;
      last_out <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_width_16to8.sv
// tb_width_16to8: directed checks of the 16-to-8 unpacker in both byte orders
module tb_width_16to8;
  logic clk = 1'b0;
  logic rst, valid_in, ready_out;
  logic [15:0] data_in;
  logic ready_in, valid_out, last_out;
  logic [7:0] data_out;
  logic ready_in_l, valid_out_l, last_out_l;
  logic [7:0] data_out_l;
  int errors = 0;
  int checks = 0;

  width_16to8 #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .last_out(last_out), .ready_out(ready_out)
  );
  width_16to8 #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in_l),
    .valid_out(valid_out_l), .data_out(data_out_l), .last_out(last_out_l), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l);
    chk1({tag, ".valid"}, valid_out, v);
    chk8({tag, ".data"}, data_out, d);
    chk1({tag, ".last"}, last_out, l);
  endtask

  logic [15:0] words [3];

  initial begin
    words[0] = 16'h0102;
    words[1] = 16'h0304;
    words[2] = 16'h0506;
    // reset held with a word offered
    rst = 1'b1; valid_in = 1'b1; data_in = 16'hABCD; ready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk1("rst.ready_in", ready_in, 1'b0);
      chk_out("rst", 1'b0, 8'h00, 1'b0);
    end
    rst = 1'b0; valid_in = 1'b0;
    cyc;
    chk_out("post_rst", 1'b0, 8'h00, 1'b0);
    chk1("post_rst.ready_in", ready_in, 1'b1);
    // single word
    valid_in = 1'b1; data_in = 16'h1234;
    #1;
    chk1("single.ready_T", ready_in, 1'b1);
    cyc;
    valid_in = 1'b0;
    chk_out("single.T1", 1'b1, 8'h12, 1'b0);
    chk1("single.ready_T1", ready_in, 1'b0);
    cyc;
    chk_out("single.T2", 1'b1, 8'h34, 1'b1);
    chk1("single.ready_T2", ready_in, 1'b1);
    cyc;
    chk_out("single.T3", 1'b0, 8'h34, 1'b0);
    // streaming three words back-to-back
    valid_in = 1'b1; data_in = words[0];
    for (int i = 0; i < 6; i++) begin
      cyc;
      chk_out("stream", 1'b1, 8'(i + 1), 1'(i % 2));
      chk1("stream.ready_in", ready_in, 1'(i % 2));
      if (i % 2 == 0) begin
        if (i / 2 + 1 < 3) data_in = words[i / 2 + 1];
        else valid_in = 1'b0;
      end
    end
    cyc;
    chk_out("stream.end", 1'b0, 8'h06, 1'b0);
    // back-pressure with a second word waiting
    valid_in = 1'b1; data_in = 16'hA55A; ready_out = 1'b0;
    cyc;
    data_in = 16'h7788;
    for (int k = 0; k < 4; k++) begin
      chk_out("stall.hi", 1'b1, 8'hA5, 1'b0);
      chk1("stall.ready_in", ready_in, 1'b0);
      if (k < 3) cyc;
    end
    ready_out = 1'b1;
    #1;
    chk1("release.ready_in", ready_in, 1'b0);
    cyc;
    chk_out("release.lo", 1'b1, 8'h5A, 1'b1);
    chk1("release.ready_lo", ready_in, 1'b1);
    ready_out = 1'b0;
    #1;
    chk1("stall_lo.ready_in", ready_in, 1'b0);
    cyc;
    chk_out("stall_lo.hold", 1'b1, 8'h5A, 1'b1);
    ready_out = 1'b1;
    cyc;
    valid_in = 1'b0;
    chk_out("second.hi", 1'b1, 8'h77, 1'b0);
    cyc;
    chk_out("second.lo", 1'b1, 8'h88, 1'b1);
    cyc;
    chk_out("second.end", 1'b0, 8'h88, 1'b0);
    // byte order, both instances
    valid_in = 1'b1; data_in = 16'hBEEF;
    cyc;
    valid_in = 1'b0;
    chk1("lsb.v0", valid_out_l, 1'b1);
    chk8("lsb.d0", data_out_l, 8'hEF);
    chk1("lsb.l0", last_out_l, 1'b0);
    chk8("msb.d0", data_out, 8'hBE);
    cyc;
    chk8("lsb.d1", data_out_l, 8'hBE);
    chk1("lsb.l1", last_out_l, 1'b1);
    chk8("msb.d1", data_out, 8'hEF);
    cyc;
    chk1("lsb.end", valid_out_l, 1'b0);
    chk1("lsb.ready_in", ready_in_l, 1'b1);
    // reset in the middle of a word
    valid_in = 1'b1; data_in = 16'hC0DE; ready_out = 1'b0;
    cyc;
    valid_in = 1'b0;
    chk_out("midrst.hi", 1'b1, 8'hC0, 1'b0);
    rst = 1'b1;
    cyc;
    chk_out("midrst.rst", 1'b0, 8'h00, 1'b0);
    chk1("midrst.ready_in", ready_in, 1'b0);
    rst = 1'b0; ready_out = 1'b1;
    cyc;
    chk_out("midrst.after", 1'b0, 8'h00, 1'b0);
    valid_in = 1'b1; data_in = 16'h1111;
    cyc;
    valid_in = 1'b0;
    chk_out("fresh.hi", 1'b1, 8'h11, 1'b0);
    cyc;
    chk_out("fresh.lo", 1'b1, 8'h11, 1'b1);
    cyc;
    chk_out("fresh.end", 1'b0, 8'h11, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/width_16to8.md
Name: width_16to8

Overview:
- Unpacks 16-bit words into two consecutive 8-bit bytes; inverse of the 8-to-16 packing path in the clock/width-conversion library.
- Sits between a 16-bit producer and an 8-bit consumer.
- Valid/ready handshake on both sides, so a stalled consumer back-pressures the producer without dropping data.
- Sustains 1 byte/cycle when the consumer never stalls.

Parameters:
MSB_FIRST, 1, 1: byte order is data_in[15:8] then data_in[7:0] (matches the 8-to-16 packer, first byte → high half); 0: [7:0] then [15:8].

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
valid_in  input  1  upstream word valid
data_in  input  16  upstream word; sampled only on accept (valid_in && ready_in)
ready_in  output  1  block can accept a word this cycle (combinational)
valid_out  output  1  data_out holds a valid byte (registered)
data_out  output  8  output byte (registered)
last_out  output  1  high with the second byte of each word (registered)
ready_out  input  1  downstream accepts the byte this cycle

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high, sampled on the rising edge.
- Reset values: state=IDLE, valid_out=0, data_out=8'h00, last_out=0, word register=16'h0000. ready_in is forced to 0 while rst=1.
- Reset mid-word: any unsent byte is discarded. No output activity on the cycle after reset deasserts.
- Handshake events:
  - Input accept = valid_in && ready_in.
  - Output transfer = valid_out && ready_out.
  - ready_out is ignored while valid_out=0.
- Output stability: while valid_out=1 && ready_out=0, data_out and last_out hold constant, and valid_out must not drop.
- ready_in = !rst && (state==IDLE || (state==SEND_LO && ready_out)).
- FSM (registered outputs):
  - IDLE: valid_out=0. On accept: latch data_in, data_out<=first byte, last_out<=0, valid_out<=1, go to SEND_HI.
  - SEND_HI: on transfer: data_out<=second byte, last_out<=1, go to SEND_LO. Otherwise hold.
  - SEND_LO on transfer, with a same-cycle accept: latch the new word, data_out<=its first byte, last_out<=0, stay valid, go to SEND_HI. The word is back-to-back with no bubble.
  - SEND_LO on transfer, no accept: valid_out<=0, last_out<=0, go to IDLE. data_out keeps its last value.
  - SEND_LO, no transfer: hold.
- Latency: first byte appears on valid_out the cycle after accept. The second byte follows the first byte's transfer by one cycle.
- Throughput: with ready_out tied high, a continuous valid_in stream gives one accept every 2 cycles and valid_out high every cycle.
- No data reordering, duplication or loss. Exactly 2 output transfers per accepted word, in byte order per MSB_FIRST.
- valid_in deasserting while ready_in=0 is legal. The block never samples data_in without an accept.

Test Plan:
1. Reset/idle: hold rst=1 for 3 cycles with valid_in=1, data_in=16'hABCD → ready_in=0, valid_out=0, data_out=8'h00, last_out=0 throughout; no bytes emitted afterward unless valid_in is still asserted.
2. Single word, MSB_FIRST=1, ready_out=1: accept 16'h1234 at cycle T → valid_out=1 with data_out=8'h12/last_out=0 at T+1, 8'h34/last_out=1 at T+2, valid_out=0 at T+3; ready_in=1 at T+2.
3. Streaming: words 16'h0102, 16'h0304, 16'h0506 presented back-to-back, ready_out=1 → output bytes 01,02,03,04,05,06 on 6 consecutive cycles, last_out=0,1,0,1,0,1; accepts occur every 2 cycles.
4. Back-pressure: word 16'hA55A, ready_out=0 for 4 cycles after valid_out rises → data_out stays 8'hA5 and ready_in stays 0 for the stall; after release, 8'hA5 then 8'h5A transfer; a second word held on valid_in is accepted only in the cycle 8'h5A transfers.
5. Byte order: MSB_FIRST=0, word 16'hBEEF → bytes 8'hEF (last_out=0) then 8'hBE (last_out=1).
6. Reset mid-word: accept 16'hC0DE, stall ready_out until data_out=8'hC0, assert rst for 1 cycle → valid_out=0, last_out=0, data_out=8'h00 next cycle; 8'hDE never appears; a fresh word 16'h1111 afterward yields 8'h11, 8'h11 normally.
